// File: rtl/tagv_write_ctrl.sv
// tagv_write_ctrl: sequences refill, line-invalidate and IBAR sweep writes into the icache tag/valid array.
// Optional TAGV_RESET_SWEEP_EN: clear the whole array automatically after reset release.
module tagv_write_ctrl #(
  parameter int SET_NUM = 64,
  parameter int WAY_NUM = 4,
  parameter int INDEX_W = 6
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       refill_valid,
  input  logic [$clog2(WAY_NUM)-1:0] refill_way,
  input  logic [31:0]                refill_addr,
  output logic                       refill_ready,
  input  logic                       inv_valid,
  input  logic [WAY_NUM-1:0]         inv_way_mask,
  input  logic [31:0]                inv_addr,
  output logic                       inv_ready,
  input  logic                       ibar_valid,
  output logic                       ibar_ready,
  output logic                       ibar_done,
  output logic [WAY_NUM-1:0]         tagv_we,
  output logic [31:0]                tagv_w_addr,
  output logic [31:0]                tagv_addr_rbuf,
  output logic                       tagv_clear,
  output logic                       ibar_clear,
  output logic [INDEX_W-1:0]         ibar_tagv_addr,
  output logic                       busy
);
  typedef enum logic [1:0] {IDLE, WR, SWEEP, DONE} state_t;
  state_t r_state, w_state_nxt;
  logic [WAY_NUM-1:0] r_we, w_we_nxt;
  logic [31:0] r_w_addr, w_w_addr_nxt, r_rbuf, w_rbuf_nxt;
  logic r_clear, w_clear_nxt, r_ibar_clear, w_ibar_clear_nxt, r_done, w_done_nxt, r_busy;
  logic [INDEX_W-1:0] r_cnt, w_cnt_nxt;
  logic r_init, w_idle;
`ifdef TAGV_RESET_SWEEP_EN
  // Marks the automatic post-reset sweep; blocks grants and suppresses ibar_done until it ends.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_init <= 1'b1;
    else if (r_state == DONE) r_init <= 1'b0;
`else
  assign r_init = 1'b0;
`endif
  // Grants are gated by rstn so every output reads 0 while reset is held.
  assign w_idle = (r_state == IDLE) && rstn && !r_init;
  assign refill_ready = w_idle && refill_valid;
  assign inv_ready = w_idle && inv_valid && !refill_valid;
  assign ibar_ready = w_idle && ibar_valid && !refill_valid && !inv_valid;
  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt = '0;
    w_w_addr_nxt = r_w_addr;
    w_rbuf_nxt = r_rbuf;
    w_clear_nxt = 1'b0;
    w_ibar_clear_nxt = 1'b0;
    w_done_nxt = 1'b0;
    w_cnt_nxt = r_cnt;
    case (r_state)
      IDLE: begin
        if (r_init || ibar_ready) begin
          w_state_nxt = SWEEP;
          w_we_nxt = '1;
          w_clear_nxt = 1'b1;
          w_ibar_clear_nxt = 1'b1;
        end else if (refill_ready) begin
          w_state_nxt = WR;
          w_we_nxt = WAY_NUM'(1) << refill_way;
          w_w_addr_nxt = refill_addr;
        end else if (inv_ready) begin
          w_state_nxt = WR;
          w_we_nxt = inv_way_mask;
          w_rbuf_nxt = inv_addr;
          w_clear_nxt = 1'b1;
        end
      end
      WR: w_state_nxt = IDLE;
      SWEEP: begin
        if (r_cnt == INDEX_W'(SET_NUM - 1)) begin
          w_state_nxt = DONE;
          w_cnt_nxt = '0;
          w_done_nxt = !r_init;
        end else begin
          w_cnt_nxt = r_cnt + INDEX_W'(1);
          w_we_nxt = '1;
          w_clear_nxt = 1'b1;
          w_ibar_clear_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_state <= IDLE;
      r_we <= '0;
      r_w_addr <= '0;
      r_rbuf <= '0;
      r_clear <= 1'b0;
      r_ibar_clear <= 1'b0;
      r_done <= 1'b0;
      r_cnt <= '0;
      r_busy <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we <= w_we_nxt;
      r_w_addr <= w_w_addr_nxt;
      r_rbuf <= w_rbuf_nxt;
      r_clear <= w_clear_nxt;
      r_ibar_clear <= w_ibar_clear_nxt;
      r_done <= w_done_nxt;
      r_cnt <= w_cnt_nxt;
      r_busy <= w_state_nxt != IDLE;
    end
  assign tagv_we = r_we;
  assign tagv_w_addr = r_w_addr;
  assign tagv_addr_rbuf = r_rbuf;
  assign tagv_clear = r_clear;
  assign ibar_clear = r_ibar_clear;
  assign ibar_done = r_done;
  assign ibar_tagv_addr = r_cnt;
  assign busy = r_busy || (r_init && rstn);
endmodule

// File: tb/tb_tagv_write_ctrl.sv
// tb_tagv_write_ctrl: scoreboard bench; tasks push expected array writes, a negedge monitor pops and compares them.
module tb_tagv_write_ctrl;
  logic clk = 1'b0, rstn = 1'b0;
  logic refill_valid = 1'b0, inv_valid = 1'b0, ibar_valid = 1'b0;
  logic [1:0] refill_way = '0;
  logic [31:0] refill_addr = '0, inv_addr = '0;
  logic [3:0] inv_way_mask = '0;
  logic refill_ready, inv_ready, ibar_ready, ibar_done, tagv_clear, ibar_clear, busy;
  logic [3:0] tagv_we;
  logic [31:0] tagv_w_addr, tagv_addr_rbuf;
  logic [5:0] ibar_tagv_addr;
  int total = 0, bad = 0;
  typedef struct {int kind; logic [3:0] we; logic clr; logic iclr; logic done; logic [31:0] addr;} exp_t;
  exp_t q[$];

  tagv_write_ctrl dut (
    .clk(clk), .rstn(rstn),
    .refill_valid(refill_valid), .refill_way(refill_way), .refill_addr(refill_addr), .refill_ready(refill_ready),
    .inv_valid(inv_valid), .inv_way_mask(inv_way_mask), .inv_addr(inv_addr), .inv_ready(inv_ready),
    .ibar_valid(ibar_valid), .ibar_ready(ibar_ready), .ibar_done(ibar_done),
    .tagv_we(tagv_we), .tagv_w_addr(tagv_w_addr), .tagv_addr_rbuf(tagv_addr_rbuf),
    .tagv_clear(tagv_clear), .ibar_clear(ibar_clear), .ibar_tagv_addr(ibar_tagv_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  // kind 0 refill, 1 invalidate, 2 sweep step, 3 ibar_done pulse
  always @(negedge clk)
    if (rstn && (tagv_we != 4'b0 || tagv_clear || ibar_clear || ibar_done)) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: we=%b clr=%b iclr=%b done=%b idx=%0d", tagv_we, tagv_clear, ibar_clear, ibar_done, ibar_tagv_addr);
      end else begin
        exp_t e;
        logic ok;
        e = q.pop_front();
        ok = {tagv_we, tagv_clear, ibar_clear, ibar_done} === {e.we, e.clr, e.iclr, e.done};
        if (e.kind == 0) ok = ok && (tagv_w_addr === e.addr);
        if (e.kind == 1) ok = ok && (tagv_addr_rbuf === e.addr);
        if (e.kind == 2) ok = ok && (ibar_tagv_addr === e.addr[5:0]);
        if (!ok) begin
          bad++;
          $display("FAIL write_kind%0d: got we=%b clr=%b iclr=%b done=%b waddr=%h rbuf=%h idx=%0d, want we=%b clr=%b iclr=%b done=%b addr=%h",
                   e.kind, tagv_we, tagv_clear, ibar_clear, ibar_done, tagv_w_addr, tagv_addr_rbuf, ibar_tagv_addr,
                   e.we, e.clr, e.iclr, e.done, e.addr);
        end
      end
    end

  task push_sweep(input bit with_done);
    for (int i = 0; i < 64; i++) q.push_back('{2, 4'hf, 1'b1, 1'b1, 1'b0, 32'(i)});
    if (with_done) q.push_back('{3, 4'h0, 1'b0, 1'b0, 1'b1, 32'h0});
  endtask

  task release_reset;
    @(posedge clk);
    #1 rstn = 1'b1;
`ifdef TAGV_RESET_SWEEP_EN
    refill_valid = 1'b1;
    refill_way = 2'd3;
    refill_addr = 32'h0000_1234;
    push_sweep(1'b0);
    for (int k = 0; k <= 66; k++) begin
      @(negedge clk);
      total++;
      if (refill_ready !== (k == 66)) begin
        bad++;
        $display("FAIL reset_sweep_ready: cycle=%0d got=%b want=%b", k, refill_ready, k == 66);
      end
      if (k == 66) q.push_back('{0, 4'b1000, 1'b0, 1'b0, 1'b0, 32'h0000_1234});
    end
    @(posedge clk);
    #1 refill_valid = 1'b0;
    repeat (2) @(negedge clk);
`endif
  endtask

  task test_reset;
    refill_valid = 1'b1;
    #12;
    total++;
    if ({refill_ready, inv_ready, ibar_ready, ibar_done, tagv_we, tagv_w_addr, tagv_addr_rbuf, tagv_clear, ibar_clear, ibar_tagv_addr, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: we=%b waddr=%h rbuf=%h busy=%b rdy=%b, want all zero", tagv_we, tagv_w_addr, tagv_addr_rbuf, busy, refill_ready);
    end
    refill_valid = 1'b0;
    release_reset();
  endtask

  task test_refill;
    @(posedge clk);
    #1 refill_valid = 1'b1;
    refill_way = 2'd2;
    refill_addr = 32'h1C00_0A40;
    @(negedge clk);
    total++;
    if (refill_ready !== 1'b1) begin bad++; $display("FAIL refill_ready: got=%b want=1", refill_ready); end
    q.push_back('{0, 4'b0100, 1'b0, 1'b0, 1'b0, 32'h1C00_0A40});
    @(posedge clk);
    #1 refill_valid = 1'b0;
    inv_valid = 1'b1;
    inv_way_mask = 4'b1111;
    @(negedge clk);
    total++;
    if ({busy, inv_ready} !== 2'b10) begin bad++; $display("FAIL refill_wr_cycle: busy,inv_ready got=%b want=10", {busy, inv_ready}); end
    @(posedge clk);
    #1 inv_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, inv_ready} !== 2'b00) begin bad++; $display("FAIL refill_idle_after: busy,inv_ready got=%b want=00", {busy, inv_ready}); end
  endtask

  task test_inv(input logic [3:0] mask, input logic [31:0] addr);
    @(posedge clk);
    #1 inv_valid = 1'b1;
    inv_way_mask = mask;
    inv_addr = addr;
    @(negedge clk);
    total++;
    if (inv_ready !== 1'b1) begin bad++; $display("FAIL inv_ready: got=%b want=1", inv_ready); end
    q.push_back('{1, mask, 1'b1, 1'b0, 1'b0, addr});
    @(posedge clk);
    #1 inv_valid = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || tagv_addr_rbuf[11:6] !== addr[11:6]) begin
      bad++;
      $display("FAIL inv_wr_cycle: busy=%b idx=%0d want busy=1 idx=%0d", busy, tagv_addr_rbuf[11:6], addr[11:6]);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL inv_idle_after: busy got=%b want=0", busy); end
  endtask

  task test_ibar;
    @(posedge clk);
    #1 ibar_valid = 1'b1;
    @(negedge clk);
    total++;
    if (ibar_ready !== 1'b1) begin bad++; $display("FAIL ibar_ready: got=%b want=1", ibar_ready); end
    push_sweep(1'b1);
    @(posedge clk);
    #1 ibar_valid = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || ibar_done !== 1'b0) begin bad++; $display("FAIL ibar_sweep_busy: step=%0d busy=%b done=%b want 1,0", k, busy, ibar_done); end
    end
    @(negedge clk);
    total++;
    if ({busy, ibar_done, tagv_we} !== 6'b110000) begin bad++; $display("FAIL ibar_done_cycle: busy,done,we got=%b want=110000", {busy, ibar_done, tagv_we}); end
    @(negedge clk);
    total++;
    if ({busy, ibar_done} !== 2'b00) begin bad++; $display("FAIL ibar_idle_after: busy,done got=%b want=00", {busy, ibar_done}); end
  endtask

  task test_priority;
    logic [2:0] want;
    @(posedge clk);
    #1 refill_valid = 1'b1;
    inv_valid = 1'b1;
    ibar_valid = 1'b1;
    refill_way = 2'd1;
    refill_addr = 32'hABCD_E080;
    inv_way_mask = 4'b0110;
    inv_addr = 32'h0000_0100;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      want = (k == 0) ? 3'b100 : (k == 2) ? 3'b010 : (k == 4) ? 3'b001 : 3'b000;
      total++;
      if ({refill_ready, inv_ready, ibar_ready} !== want) begin
        bad++;
        $display("FAIL priority_ready: cycle=%0d got=%b want=%b", k, {refill_ready, inv_ready, ibar_ready}, want);
      end
      if (k == 0) q.push_back('{0, 4'b0010, 1'b0, 1'b0, 1'b0, 32'hABCD_E080});
      if (k == 2) q.push_back('{1, 4'b0110, 1'b1, 1'b0, 1'b0, 32'h0000_0100});
      if (k == 4) push_sweep(1'b1);
      @(posedge clk);
      #1;
      if (k == 0) refill_valid = 1'b0;
      if (k == 2) inv_valid = 1'b0;
      if (k == 4) ibar_valid = 1'b0;
    end
    repeat (65) @(negedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL priority_end_idle: busy got=%b want=0", busy); end
  endtask

  task test_back_to_back;
    @(posedge clk);
    #1 refill_valid = 1'b1;
    refill_way = 2'd0;
    refill_addr = 32'h0000_3000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++;
      if (refill_ready !== (k % 2 == 0)) begin bad++; $display("FAIL b2b_ready: cycle=%0d got=%b want=%b", k, refill_ready, k % 2 == 0); end
      if (k % 2 == 0) q.push_back('{0, 4'b0001 << refill_way, 1'b0, 1'b0, 1'b0, refill_addr});
      @(posedge clk);
      #1;
      if (k % 2 == 0) begin
        refill_way = refill_way + 2'd1;
        refill_addr = refill_addr + 32'h40;
      end
    end
    refill_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task test_reset_mid_sweep;
    @(posedge clk);
    #1 ibar_valid = 1'b1;
    @(negedge clk);
    total++;
    if (ibar_ready !== 1'b1) begin bad++; $display("FAIL midrst_ibar_ready: got=%b want=1", ibar_ready); end
    push_sweep(1'b1);
    @(posedge clk);
    #1 ibar_valid = 1'b0;
    repeat (21) @(negedge clk);
    total++;
    if (ibar_tagv_addr !== 6'd20) begin bad++; $display("FAIL midrst_index: got=%0d want=20", ibar_tagv_addr); end
    #1 rstn = 1'b0;
    q.delete();
    #1;
    total++;
    if ({ibar_done, tagv_we, tagv_clear, ibar_clear, ibar_tagv_addr, busy} !== '0) begin
      bad++;
      $display("FAIL midrst_outputs: we=%b clr=%b iclr=%b idx=%0d busy=%b want all zero", tagv_we, tagv_clear, ibar_clear, ibar_tagv_addr, busy);
    end
    repeat (2) @(posedge clk);
    release_reset();
    repeat (5) @(negedge clk);
    test_ibar();
  endtask

  initial begin
    test_reset();
    test_refill();
    test_inv(4'b1001, 32'h0000_0FC0);
    test_inv(4'b0000, 32'h0000_0040);
    test_ibar();
    test_priority();
    test_back_to_back();
    test_reset_mid_sweep();
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL missing_writes: pending=%0d want=0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
